// File: rtl/dram_write_coalescer_pkg.sv
// System-wide TileAccumUnit configuration shared by the write pipeline blocks.
// WCOAL_N_LINE is the default line-buffer depth for dram_write_coalescer.
package TauCfg;
   localparam int VSIZE          = 4;
   localparam int CACHE_SIZE     = 4;
   localparam int DATA_BW        = 32;
   localparam int GLOBAL_ADDR_BW = 16;
   localparam int WCOAL_N_LINE   = 2;
endpackage

// File: rtl/dram_write_coalescer_line_group_select.sv
// Combinational: picks the lowest pending lane's line tag, the lanes sharing it,
// and for each word offset the highest-index group lane writing that word.
module LineGroupSelect #(
   parameter int VSIZE = 4,
   parameter int CSIZE = 4,
   parameter int GBW   = 16,
   localparam int CC_BW = $clog2(CSIZE),
   localparam int LW    = (VSIZE > 1) ? $clog2(VSIZE) : 1,
   localparam int TW    = GBW - CC_BW
) (
   input  logic [VSIZE-1:0][GBW-1:0] addr,
   input  logic [VSIZE-1:0]          pending,
   output logic [TW-1:0]             tag,
   output logic [VSIZE-1:0]          group,
   output logic [CSIZE-1:0]          win_vld,
   output logic [CSIZE-1:0][LW-1:0]  win_lane
);
   always_comb begin
      tag      = '0;
      group    = '0;
      win_vld  = '0;
      win_lane = '0;
      for (int i = VSIZE - 1; i >= 0; i--) begin
         if (pending[i]) tag = addr[i][GBW-1:CC_BW];
      end
      for (int i = 0; i < VSIZE; i++) begin
         group[i] = pending[i] && (addr[i][GBW-1:CC_BW] == tag);
      end
      // ascending scan: a later (higher) lane overwrites the same offset
      for (int i = 0; i < VSIZE; i++) begin
         if (group[i]) begin
            win_vld[addr[i][CC_BW-1:0]]  = 1'b1;
            win_lane[addr[i][CC_BW-1:0]] = LW'(i);
         end
      end
   end
endmodule

// File: rtl/dram_write_coalescer.sv
// Merges address+data warps into an N_LINE line buffer and emits masked line writes; 1 cycle
// accept-to-merge, one line group per MERGE cycle; evictions stall until dramw_ack.
module dram_write_coalescer #(
   parameter int VSIZE  = TauCfg::VSIZE,
   parameter int CSIZE  = TauCfg::CACHE_SIZE,
   parameter int DBW    = TauCfg::DATA_BW,
   parameter int GBW    = TauCfg::GLOBAL_ADDR_BW,
   parameter int N_LINE = TauCfg::WCOAL_N_LINE
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      addrval_rdy,
   output logic                      addrval_ack,
   input  logic [VSIZE-1:0][GBW-1:0] i_address,
   input  logic [VSIZE-1:0]          i_valid,
   input  logic                      alu_dat_rdy,
   output logic                      alu_dat_ack,
   input  logic [VSIZE-1:0][DBW-1:0] i_alu_dat,
   input  logic                      flush_rdy,
   output logic                      flush_ack,
   output logic                      dramw_rdy,
   input  logic                      dramw_ack,
   output logic [GBW-1:0]            o_dramwa,
   output logic [CSIZE-1:0][DBW-1:0] o_dramwd,
   output logic [CSIZE-1:0]          o_dramw_mask
);
   localparam int CC_BW = $clog2(CSIZE);
   localparam int TW    = GBW - CC_BW;
   localparam int LW    = (VSIZE > 1) ? $clog2(VSIZE) : 1;
   localparam int IW    = (N_LINE > 1) ? $clog2(N_LINE) : 1;
   localparam int AW    = IW;

   // age is an allocation rank among valid entries: 0 is the oldest
   typedef struct packed {
      logic                      valid;
      logic [TW-1:0]             tag;
      logic [AW-1:0]             age;
      logic [CSIZE-1:0]          mask;
      logic [CSIZE-1:0][DBW-1:0] data;
   } entry_t;

   typedef enum logic [1:0] {IDLE, MERGE, EVICT, FLUSH} state_t;

   state_t                      state, ret;
   entry_t                      ent [N_LINE];
   logic [VSIZE-1:0][GBW-1:0]   addr_q;
   logic [VSIZE-1:0][DBW-1:0]   data_q;
   logic [VSIZE-1:0]            pending;
   logic [IW-1:0]               vic;

   logic [TW-1:0]               grp_tag;
   logic [VSIZE-1:0]            group;
   logic [CSIZE-1:0]            win_vld;
   logic [CSIZE-1:0][LW-1:0]    win_lane;

   logic                        hit, free_vld, any_valid, merge_ok, start_ev;
   logic [IW-1:0]               hit_idx, free_idx, old_idx, tgt, ev_idx;
   logic [AW:0]                 nvalid;
   entry_t                      mer, ev_src;

   LineGroupSelect #(.VSIZE(VSIZE), .CSIZE(CSIZE), .GBW(GBW)) u_sel (
      .addr     (addr_q),
      .pending  (pending),
      .tag      (grp_tag),
      .group    (group),
      .win_vld  (win_vld),
      .win_lane (win_lane)
   );

   always_comb begin
      hit       = 1'b0;
      hit_idx   = '0;
      free_vld  = 1'b0;
      free_idx  = '0;
      old_idx   = '0;
      any_valid = 1'b0;
      nvalid    = '0;
      for (int i = N_LINE - 1; i >= 0; i--) begin
         if (ent[i].valid && ent[i].tag == grp_tag) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
         if (!ent[i].valid) begin
            free_vld = 1'b1;
            free_idx = IW'(i);
         end
         if (ent[i].valid && ent[i].age == '0) old_idx = IW'(i);
         if (ent[i].valid) begin
            any_valid = 1'b1;
            nvalid    = nvalid + (AW+1)'(1);
         end
      end
      tgt = hit ? hit_idx : free_idx;
      mer = ent[tgt];
      if (!hit) begin
         mer.valid = 1'b1;
         mer.tag   = grp_tag;
         mer.age   = nvalid[AW-1:0];
         mer.mask  = '0;
      end
      for (int o = 0; o < CSIZE; o++) begin
         if (win_vld[o]) begin
            mer.mask[o] = 1'b1;
            mer.data[o] = data_q[win_lane[o]];
         end
      end
      merge_ok = (state == MERGE) && (pending != '0) && (hit || free_vld);
      // a full line leaves straight from the merge result; otherwise the oldest entry goes
      start_ev = ((state == MERGE) && (pending != '0) && !(hit || free_vld)) ||
                 (merge_ok && (&mer.mask)) ||
                 ((state == FLUSH) && any_valid);
      ev_src   = merge_ok ? mer : ent[old_idx];
      ev_idx   = merge_ok ? tgt : old_idx;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state        <= IDLE;
         ret          <= IDLE;
         addrval_ack  <= 1'b0;
         alu_dat_ack  <= 1'b0;
         flush_ack    <= 1'b0;
         dramw_rdy    <= 1'b0;
         o_dramwa     <= '0;
         o_dramwd     <= '0;
         o_dramw_mask <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         pending      <= '0;
         vic          <= '0;
         for (int i = 0; i < N_LINE; i++) ent[i] <= '0;
      end else begin
         flush_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (addrval_ack) begin
                  addrval_ack <= 1'b0;
                  alu_dat_ack <= 1'b0;
                  addr_q      <= i_address;
                  data_q      <= i_alu_dat;
                  pending     <= i_valid;
                  if (|i_valid) state <= MERGE;
               end else if (addrval_rdy && alu_dat_rdy) begin
                  addrval_ack <= 1'b1;
                  alu_dat_ack <= 1'b1;
               end else if (flush_rdy && !flush_ack) begin
                  state <= FLUSH;
               end
            end
            MERGE: begin
               if (pending == '0) begin
                  state <= IDLE;
               end else if (hit || free_vld) begin
                  ent[tgt] <= mer;
                  pending  <= pending & ~group;
                  if (&mer.mask) state <= EVICT;
                  else if ((pending & ~group) == '0) state <= IDLE;
               end else begin
                  state <= EVICT;
               end
            end
            EVICT: begin
               if (dramw_ack) begin
                  dramw_rdy <= 1'b0;
                  for (int j = 0; j < N_LINE; j++) begin
                     if (ent[j].valid && ent[j].age > ent[vic].age)
                        ent[j].age <= ent[j].age - AW'(1);
                  end
                  ent[vic].valid <= 1'b0;
                  state          <= ret;
               end
            end
            FLUSH: begin
               if (any_valid) begin
                  state <= EVICT;
               end else begin
                  flush_ack <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         if (start_ev) begin
            ret          <= state;
            vic          <= ev_idx;
            dramw_rdy    <= 1'b1;
            o_dramwa     <= {ev_src.tag, {CC_BW{1'b0}}};
            o_dramwd     <= ev_src.data;
            o_dramw_mask <= ev_src.mask;
         end
      end
   end
endmodule
